// File: rtl/canny_pkg.sv
// Shared constants and types for the Canny Sobel gradient stage.
//   DW      : tap data width (unsigned pixels from the window generator)
//   IMG_W/H : default frame geometry
//   GRAD_W  : signed Gx/Gy width (covers +/-32764 without overflow)
//   MAG_W   : |Gx|+|Gy| width (max 65528)
//   dir_e   : quantised gradient direction used by non-maximum suppression
package canny_pkg;
  localparam int DW      = 13;
  localparam int IMG_W   = 1024;
  localparam int IMG_H   = 768;
  localparam int GRAD_W  = 17;
  localparam int MAG_W   = 16;
  localparam int SAT_MAX = (1 << DW) - 1;

  typedef enum logic [1:0] {
    DIR_0   = 2'd0,
    DIR_45  = 2'd1,
    DIR_90  = 2'd2,
    DIR_135 = 2'd3
  } dir_e;
endpackage

// File: rtl/canny_sobel_grad_if.sv
// Bundle between the 3x3 window generator, the Sobel gradient stage and its
// consumer.
//   master : upstream side, drives frame_start, din_vld, a1..a9 and observes
//            dout_vld, mag, dir, border
//   slave  : the gradient stage itself
// Handshake: din_vld qualifies a1..a9 for exactly one clock and dout_vld
// qualifies mag/dir/border for exactly one clock. There is no ready signal;
// every valid beat is accepted and every result must be consumed on the
// cycle it is presented.
interface canny_sobel_grad_if;
  import canny_pkg::*;

  logic             frame_start;
  logic             din_vld;
  logic [DW-1:0]    a1, a2, a3, a4, a5, a6, a7, a8, a9;
  logic             dout_vld;
  logic [MAG_W-1:0] mag;
  logic [1:0]       dir;
  logic             border;

  modport master (
    output frame_start, din_vld, a1, a2, a3, a4, a5, a6, a7, a8, a9,
    input  dout_vld, mag, dir, border
  );

  modport slave (
    input  frame_start, din_vld, a1, a2, a3, a4, a5, a6, a7, a8, a9,
    output dout_vld, mag, dir, border
  );
endinterface

// File: rtl/canny_dir_quant.sv
// Registered stage-3 direction quantiser.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : stage-2 data valid; the register holds when low
//   clr        : pixel lies in the unfilled border, direction forced to 0
//   ax, ay     : |Gx|, |Gy|
//   sx, sy     : sign bits of Gx, Gy (1 = negative, zero counts as positive)
//   dir        : quantised direction
// The tan(22.5)/tan(67.5) thresholds are approximated by 2/5 and 5/2, so the
// tests are 5*ay <= 2*ax (near horizontal gradient) and 2*ay >= 5*ax (near
// vertical). Products are formed at 19 bits so nothing is truncated.
module canny_dir_quant
  import canny_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [MAG_W-1:0] ax,
  input  logic [MAG_W-1:0] ay,
  input  logic             sx,
  input  logic             sy,
  output dir_e             dir
);
  logic [18:0] ax_x2, ax_x5, ay_x2, ay_x5;
  dir_e        dir_c;

  assign ax_x2 = {2'b00, ax, 1'b0};
  assign ay_x2 = {2'b00, ay, 1'b0};
  assign ax_x5 = {3'b000, ax} + {1'b0, ax, 2'b00};
  assign ay_x5 = {3'b000, ay} + {1'b0, ay, 2'b00};

  // Gx = Gy = 0 lands in the first branch (0 <= 0), giving DIR_0.
  always_comb begin
    dir_c = DIR_0;
    if (clr)                 dir_c = DIR_0;
    else if (ay_x5 <= ax_x2) dir_c = DIR_0;
    else if (ay_x2 >= ax_x5) dir_c = DIR_90;
    else if (sx == sy)       dir_c = DIR_45;
    else                     dir_c = DIR_135;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  dir <= DIR_0;
    else if (en) dir <= dir_c;
  end
endmodule

// File: rtl/canny_sobel_grad.sv
// Sobel gradient stage of the Canny pipeline.
// Takes the nine 3x3 window taps each valid pixel and returns the L1 gradient
// magnitude, a 2-bit quantised direction and a border flag, 3 clocks later.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset, discards in-flight pixels
//   bus    : canny_sobel_grad_if.slave (frame_start, din_vld, a1..a9 in;
//            dout_vld, mag, dir, border out)
// Parameters: IMG_W, IMG_H frame geometry for the raster position counters.
// Build option: define CANNY_GRAD_SAT_EN to saturate mag at 2^DW-1.
// Pipeline: S1 Gx/Gy + border tag, S2 abs/signs, S3 mag/dir with border mask.
module canny_sobel_grad #(
  parameter int IMG_W = canny_pkg::IMG_W,
  parameter int IMG_H = canny_pkg::IMG_H
) (
  input  logic               clk,
  input  logic               rst_n,
  canny_sobel_grad_if.slave  bus
);
  import canny_pkg::*;

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  // ---------------- raster position ----------------
  logic [CW-1:0] col, pos_col;
  logic [RW-1:0] row, pos_row;
  logic          last_col, last_row, border_c;

  // A frame_start coincident with din_vld makes this pixel (0,0).
  assign pos_col  = bus.frame_start ? '0 : col;
  assign pos_row  = bus.frame_start ? '0 : row;
  assign last_col = (pos_col == CW'(IMG_W - 1));
  assign last_row = (pos_row == RW'(IMG_H - 1));
  assign border_c = (int'(pos_col) < 2) || (int'(pos_row) < 2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (bus.din_vld) begin
      col <= last_col ? '0 : pos_col + CW'(1);
      if (last_col) row <= last_row ? '0 : pos_row + RW'(1);
      else          row <= pos_row;
    end else if (bus.frame_start) begin
      col <= '0;
      row <= '0;
    end
  end

  // ---------------- stage 1: Gx, Gy ----------------
  // Each half-kernel sum is at most 4*8191 = 32764, which fits in DW+2 bits.
  logic [DW+1:0]            gx_p, gx_n, gy_p, gy_n;
  logic signed [GRAD_W-1:0] gx_c, gy_c, gx1, gy1;
  logic                     v1, brd1;

  assign gx_p = {2'b00, bus.a3} + {1'b0, bus.a6, 1'b0} + {2'b00, bus.a9};
  assign gx_n = {2'b00, bus.a1} + {1'b0, bus.a4, 1'b0} + {2'b00, bus.a7};
  assign gy_p = {2'b00, bus.a7} + {1'b0, bus.a8, 1'b0} + {2'b00, bus.a9};
  assign gy_n = {2'b00, bus.a1} + {1'b0, bus.a2, 1'b0} + {2'b00, bus.a3};
  assign gx_c = $signed({2'b00, gx_p}) - $signed({2'b00, gx_n});
  assign gy_c = $signed({2'b00, gy_p}) - $signed({2'b00, gy_n});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1   <= 1'b0;
      gx1  <= '0;
      gy1  <= '0;
      brd1 <= 1'b0;
    end else begin
      v1 <= bus.din_vld;
      if (bus.din_vld) begin
        gx1  <= gx_c;
        gy1  <= gy_c;
        brd1 <= border_c;
      end
    end
  end

  // ---------------- stage 2: abs and signs ----------------
  logic [GRAD_W-1:0] gx_neg, gy_neg;
  logic [MAG_W-1:0]  ax_c, ay_c, ax2, ay2;
  logic              v2, brd2, sx2, sy2;

  // |G| <= 32764, so dropping the top bit of the negation is lossless.
  assign gx_neg = -gx1;
  assign gy_neg = -gy1;
  assign ax_c   = gx1[GRAD_W-1] ? gx_neg[MAG_W-1:0] : gx1[MAG_W-1:0];
  assign ay_c   = gy1[GRAD_W-1] ? gy_neg[MAG_W-1:0] : gy1[MAG_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2   <= 1'b0;
      ax2  <= '0;
      ay2  <= '0;
      sx2  <= 1'b0;
      sy2  <= 1'b0;
      brd2 <= 1'b0;
    end else begin
      v2 <= v1;
      if (v1) begin
        ax2  <= ax_c;
        ay2  <= ay_c;
        sx2  <= gx1[GRAD_W-1];
        sy2  <= gy1[GRAD_W-1];
        brd2 <= brd1;
      end
    end
  end

  // ---------------- stage 3: magnitude, direction, mask ----------------
  logic [MAG_W:0]   mag_sum;
  logic [MAG_W-1:0] mag_c, mag3;
  logic             v3, brd3;
  dir_e             dir3;

  assign mag_sum = {1'b0, ax2} + {1'b0, ay2};

  always_comb begin
    mag_c = mag_sum[MAG_W-1:0];
`ifdef CANNY_GRAD_SAT_EN
    if (mag_sum > (MAG_W+1)'(SAT_MAX)) mag_c = MAG_W'(SAT_MAX);
`else
`endif
    if (brd2) mag_c = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3   <= 1'b0;
      mag3 <= '0;
      brd3 <= 1'b0;
    end else begin
      v3 <= v2;
      if (v2) begin
        mag3 <= mag_c;
        brd3 <= brd2;
      end
    end
  end

  canny_dir_quant u_dir (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (v2),
    .clr   (brd2),
    .ax    (ax2),
    .ay    (ay2),
    .sx    (sx2),
    .sy    (sy2),
    .dir   (dir3)
  );

  assign bus.dout_vld = v3;
  assign bus.mag      = mag3;
  assign bus.dir      = dir3;
  assign bus.border   = brd3;
endmodule

// File: tb/tb_canny_sobel_grad.sv
// Bench for canny_sobel_grad: driver task per cycle, reference model computing
// {border, dir, mag} from the taps and a tracked raster position, and a
// scoreboard popping expected results (with expected arrival cycle) whenever
// dout_vld is seen.
module tb_canny_sobel_grad;
  import canny_pkg::*;

  localparam int W = 1 + 2 + MAG_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  canny_sobel_grad_if bus();

  canny_sobel_grad dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] exp_q[$];
  int           lat_q[$];

  int tp[9];
  int m_col = 0;
  int m_row = 0;

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] model(input bit brd);
    int gx, gy, ax, ay, mg;
    logic [1:0] d;
    gx = (tp[2] + 2 * tp[5] + tp[8]) - (tp[0] + 2 * tp[3] + tp[6]);
    gy = (tp[6] + 2 * tp[7] + tp[8]) - (tp[0] + 2 * tp[1] + tp[2]);
    ax = (gx < 0) ? -gx : gx;
    ay = (gy < 0) ? -gy : gy;
    mg = ax + ay;
`ifdef CANNY_GRAD_SAT_EN
    if (mg > 8191) mg = 8191;
`endif
    if (5 * ay <= 2 * ax)            d = 2'd0;
    else if (2 * ay >= 5 * ax)       d = 2'd2;
    else if ((gx < 0) == (gy < 0))   d = 2'd1;
    else                             d = 2'd3;
    if (brd) begin
      mg = 0;
      d  = 2'd0;
    end
    return {brd, d, 16'(mg)};
  endfunction

  // ---------------- driver ----------------
  task automatic drive_px(input bit vld, input bit fs);
    bit brd;
    @(posedge clk);
    #1;
    bus.frame_start = fs;
    bus.din_vld     = vld;
    bus.a1 = DW'(tp[0]); bus.a2 = DW'(tp[1]); bus.a3 = DW'(tp[2]);
    bus.a4 = DW'(tp[3]); bus.a5 = DW'(tp[4]); bus.a6 = DW'(tp[5]);
    bus.a7 = DW'(tp[6]); bus.a8 = DW'(tp[7]); bus.a9 = DW'(tp[8]);
    if (fs) begin
      m_col = 0;
      m_row = 0;
    end
    if (vld) begin
      brd = (m_col < 2) || (m_row < 2);
      exp_q.push_back(model(brd));
      lat_q.push_back(cyc + 3);
      if (m_col == IMG_W - 1) begin
        m_col = 0;
        m_row = (m_row == IMG_H - 1) ? 0 : m_row + 1;
      end else begin
        m_col = m_col + 1;
      end
    end
  endtask

  task automatic set_taps(input int v0, v1, v2, v3, v4, v5, v6, v7, v8);
    tp[0] = v0; tp[1] = v1; tp[2] = v2; tp[3] = v3; tp[4] = v4;
    tp[5] = v5; tp[6] = v6; tp[7] = v7; tp[8] = v8;
  endtask

  task automatic rand_taps();
    for (int i = 0; i < 9; i++) tp[i] = $urandom_range(0, 8191);
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    logic [W-1:0] got, e;
    int l;
    if (bus.dout_vld === 1'b1) begin
      got = {bus.border, bus.dir, bus.mag};
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_out cyc=%0d got border=%0b dir=%0d mag=%0d, required no output",
                 cyc, got[W-1], got[W-2:W-3], got[MAG_W-1:0]);
      end else begin
        e = exp_q.pop_front();
        l = lat_q.pop_front();
        if (got !== e || cyc != l) begin
          failures++;
          $display("FAIL result cyc=%0d got border=%0b dir=%0d mag=%0d, required border=%0b dir=%0d mag=%0d at cyc=%0d",
                   cyc, got[W-1], got[W-2:W-3], got[MAG_W-1:0],
                   e[W-1], e[W-2:W-3], e[MAG_W-1:0], l);
        end
      end
    end
  end

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    bus.frame_start = 1'b0;
    bus.din_vld     = 1'b0;
    set_taps(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.dout_vld !== 1'b0 || bus.mag !== '0 || bus.dir !== 2'd0 || bus.border !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs got vld=%0b mag=%0d dir=%0d border=%0b, required all 0",
               bus.dout_vld, bus.mag, bus.dir, bus.border);
    end
    rst_n = 1'b1;
    repeat (2) drive_px(0, 0);
  endtask

  task automatic test_border_flat();
    set_taps(100, 100, 100, 100, 100, 100, 100, 100, 100);
    drive_px(0, 1);
    for (int i = 0; i < 3 * IMG_W; i++) drive_px(1, 0);
  endtask

  task automatic test_patterns();
    rand_taps();
    repeat (2) drive_px(1, 0);              // cols 0,1 of row 3 are border
    set_taps(0, 50, 100, 0, 50, 100, 0, 50, 100);
    repeat (3) drive_px(1, 0);              // mag 400 dir 0
    set_taps(0, 0, 100, 0, 50, 100, 100, 100, 100);
    repeat (2) drive_px(1, 0);              // Gx=Gy=300: mag 600 dir 1
    set_taps(100, 100, 100, 0, 50, 100, 0, 0, 100);
    repeat (2) drive_px(1, 0);              // Gx=300 Gy=-300: dir 3
    set_taps(0, 0, 0, 0, 0, 0, 100, 100, 100);
    drive_px(1, 0);                         // pure vertical: dir 2
    set_taps(7, 7, 7, 7, 7, 7, 7, 7, 7);
    drive_px(1, 0);                         // zero gradient: dir 0
    drive_px(0, 0);
  endtask

  task automatic test_saturation();
    set_taps(0, 0, 8191, 0, 0, 8191, 0, 0, 8191);
    repeat (2) drive_px(1, 0);
    set_taps(8191, 8191, 8191, 0, 0, 0, 0, 0, 0);
    drive_px(1, 0);
    drive_px(0, 0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 60; i++) begin
      rand_taps();
      drive_px(($urandom_range(0, 3) != 0), 0);
    end
  endtask

  task automatic test_toggle_frame_start();
    rand_taps();
    drive_px(1, 1);
    drive_px(0, 0);
    rand_taps();
    drive_px(1, 0);
    drive_px(0, 0);
    for (int i = 0; i < 4; i++) begin
      rand_taps();
      drive_px(1, 0);
    end
    drive_px(0, 0);
  endtask

  task automatic test_reset_mid_line();
    for (int i = 0; i < 5; i++) begin
      rand_taps();
      drive_px(1, 0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    bus.din_vld = 1'b0;
    #1;
    checks++;
    if (bus.dout_vld !== 1'b0 || bus.mag !== '0) begin
      failures++;
      $display("FAIL reset_mid got vld=%0b mag=%0d, required vld=0 mag=0",
               bus.dout_vld, bus.mag);
    end
    exp_q.delete();
    lat_q.delete();
    m_col = 0;
    m_row = 0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (2) drive_px(0, 0);
    for (int i = 0; i < 4; i++) begin
      rand_taps();
      drive_px(1, 0);
    end
  endtask

  initial begin
    bus.frame_start = 1'b0;
    bus.din_vld     = 1'b0;
    bus.a1 = '0; bus.a2 = '0; bus.a3 = '0; bus.a4 = '0; bus.a5 = '0;
    bus.a6 = '0; bus.a7 = '0; bus.a8 = '0; bus.a9 = '0;
    test_reset();
    test_border_flat();
    test_patterns();
    test_saturation();
    test_back_to_back();
    test_toggle_frame_start();
    test_reset_mid_line();
    repeat (6) drive_px(0, 0);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain got %0d results outstanding, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
